// File: rtl/params_reporter_pkg.sv
// Shared types and constants for the parameter readout frame.
// Byte positions, FSM states and the snapshot layout used by reporter and mux.
package params_reporter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam int FRAME_LEN = 8;

  localparam logic [2:0] IDX_HEADER = 3'd0;
  localparam logic [2:0] IDX_BOO    = 3'd1;
  localparam logic [2:0] IDX_INT    = 3'd2;
  localparam logic [2:0] IDX_LOG    = 3'd3;
  localparam logic [2:0] IDX_VEC    = 3'd4;
  localparam logic [2:0] IDX_STR    = 3'd5;
  localparam logic [2:0] IDX_REA    = 3'd6;
  localparam logic [2:0] IDX_CSUM   = 3'd7;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

  typedef struct packed {
    logic       boo;
    logic [7:0] intv;
    logic       log;
    logic [7:0] vec;
    logic       str;
    logic       rea;
  } snap_t;

  function automatic logic [7:0] flag_byte(input logic f);
    return {7'b0, f};
  endfunction

endpackage

// File: rtl/params_frame_mux.sv
// Combinational frame byte selector: picks byte[idx] of the 8-byte frame
// built from the snapshot, including the running XOR checksum.
module params_frame_mux
  import params_reporter_pkg::*;
#(
  parameter logic [7:0] HEADER = DEFAULT_HEADER
) (
  input  snap_t      snap,
  input  logic [2:0] idx,
  output logic [7:0] data
);

  logic [7:0] csum;

  always_comb begin
    csum = HEADER ^ flag_byte(snap.boo) ^ snap.intv ^ flag_byte(snap.log)
         ^ snap.vec ^ flag_byte(snap.str) ^ flag_byte(snap.rea);
    data = 8'h00;
    case (idx)
      IDX_HEADER: data = HEADER;
      IDX_BOO:    data = flag_byte(snap.boo);
      IDX_INT:    data = snap.intv;
      IDX_LOG:    data = flag_byte(snap.log);
      IDX_VEC:    data = snap.vec;
      IDX_STR:    data = flag_byte(snap.str);
      IDX_REA:    data = flag_byte(snap.rea);
      default:    data = csum;
    endcase
  end

endmodule

// File: rtl/params_reporter.sv
// Parameter readout controller: snapshots six parameter outputs on start and
// streams header/payload/checksum over a valid/ready byte interface.
//   state | meaning
//   IDLE  | waiting for start_i
//   SEND  | presenting byte[idx], advancing on acceptance
//   GAP   | counting idle cycles before an automatic restart (PERIOD > 0)
module params_reporter
  import params_reporter_pkg::*;
#(
  parameter logic [7:0]  HEADER = DEFAULT_HEADER,
  parameter int unsigned PERIOD = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       boo_i,
  input  logic [7:0] int_i,
  input  logic       log_i,
  input  logic [7:0] vec_i,
  input  logic       str_i,
  input  logic       rea_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       busy_o,
  output logic       done_o
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] GAP_LOAD = (PERIOD > 0) ? CNT_W'(PERIOD - 1) : '0;
  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

  state_e           state, state_n;
  logic [2:0]       idx, idx_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  snap_t            snap, snap_n, live;
  logic             done, done_n;
  logic [7:0]       frame_byte;

  assign live = {boo_i, int_i, log_i, vec_i, str_i, rea_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      idx   <= '0;
      cnt   <= '0;
      snap  <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      snap  <= snap_n;
      done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    snap_n  = snap;
    done_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          state_n = ST_SEND;
          idx_n   = '0;
          snap_n  = live;
        end
      end
      ST_SEND: begin
        if (ready_i) begin
          if (idx == LAST_IDX) begin
            done_n = 1'b1;
            idx_n  = '0;
            if (PERIOD > 0) begin
              state_n = ST_GAP;
              cnt_n   = GAP_LOAD;
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            idx_n = idx + 3'd1;
          end
        end
      end
      ST_GAP: begin
        // Expiry acts as an implicit start with a fresh snapshot.
        if (cnt == '0) begin
          state_n = ST_SEND;
          idx_n   = '0;
          snap_n  = live;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  params_frame_mux #(.HEADER(HEADER)) u_frame_mux (
    .snap (snap),
    .idx  (idx),
    .data (frame_byte)
  );

  assign valid_o = (state == ST_SEND);
  assign busy_o  = (state != ST_IDLE);
  assign data_o  = valid_o ? frame_byte : 8'h00;
  assign done_o  = done;

endmodule

// File: tb/tb_params_reporter.sv
// Self-checking bench for params_reporter: one instance without auto-restart,
// one with PERIOD=4, both compared against a byte-list frame model.
module tb_params_reporter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       boo = 1'b0;
  logic [7:0] int_v = 8'h00;
  logic       log_v = 1'b0;
  logic [7:0] vec = 8'h00;
  logic       str = 1'b0;
  logic       rea = 1'b0;
  logic       ready = 1'b0;

  logic [7:0] data0, data4;
  logic       valid0, busy0, done0;
  logic       valid4, busy4, done4;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [63:0] BASIC_FRAME = 64'hDB00_0155_012A_01A5;

  always #5 clk = ~clk;

  params_reporter #(.HEADER(8'hA5), .PERIOD(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .boo_i(boo), .int_i(int_v),
    .log_i(log_v), .vec_i(vec), .str_i(str), .rea_i(rea), .data_o(data0),
    .valid_o(valid0), .ready_i(ready), .busy_o(busy0), .done_o(done0)
  );

  params_reporter #(.HEADER(8'hA5), .PERIOD(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .boo_i(boo), .int_i(int_v),
    .log_i(log_v), .vec_i(vec), .str_i(str), .rea_i(rea), .data_o(data4),
    .valid_o(valid4), .ready_i(ready), .busy_o(busy4), .done_o(done4)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Frame as a byte list: byte k lives at bits [8k+7:8k].
  function automatic logic [63:0] model_frame(input logic b, input logic [7:0] iv,
                                              input logic l, input logic [7:0] v,
                                              input logic s, input logic r);
    logic [7:0] x;
    x = 8'hA5 ^ {7'b0, b} ^ iv ^ {7'b0, l} ^ v ^ {7'b0, s} ^ {7'b0, r};
    return {x, {7'b0, r}, {7'b0, s}, v, {7'b0, l}, iv, {7'b0, b}, 8'hA5};
  endfunction

  function automatic logic [63:0] cur_frame();
    return model_frame(boo, int_v, log_v, vec, str, rea);
  endfunction

  task automatic randomize_inputs;
    boo   = 1'($urandom_range(0, 1));
    int_v = 8'($urandom_range(0, 255));
    log_v = 1'($urandom_range(0, 1));
    vec   = 8'($urandom_range(0, 255));
    str   = 1'($urandom_range(0, 1));
    rea   = 1'($urandom_range(0, 1));
  endtask

  task automatic set_basic_inputs;
    boo = 1'b1; int_v = 8'h2A; log_v = 1'b1; vec = 8'h55; str = 1'b1; rea = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; ready = 1'b0;
    tick; tick;
    n_cmp++;
    if (data0 !== 8'h00 || valid0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_dut0: data=%h valid=%b busy=%b done=%b, required 00 0 0 0",
               data0, valid0, busy0, done0);
    end
    n_cmp++;
    if (data4 !== 8'h00 || valid4 !== 1'b0 || busy4 !== 1'b0 || done4 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_dut4: data=%h valid=%b busy=%b done=%b, required 00 0 0 0",
               data4, valid4, busy4, done4);
    end
    rst = 1'b0;
    tick;
    n_cmp++;
    if (valid0 !== 1'b0 || busy0 !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: valid=%b busy=%b, required 0 0", valid0, busy0);
    end
  endtask

  task automatic test_basic;
    set_basic_inputs;
    ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (valid0 !== 1'b1 || busy0 !== 1'b1 || done0 !== 1'b0 || data0 !== BASIC_FRAME[8*k +: 8]) begin
        n_bad++;
        $display("FAIL basic_byte%0d: data=%h valid=%b busy=%b done=%b, required %h 1 1 0",
                 k, data0, valid0, busy0, done0, BASIC_FRAME[8*k +: 8]);
      end
      tick;
    end
    n_cmp++;
    if (done0 !== 1'b1 || valid0 !== 1'b0 || busy0 !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_done: done=%b valid=%b busy=%b, required 1 0 0", done0, valid0, busy0);
    end
    tick;
    n_cmp++;
    if (done0 !== 1'b0 || busy0 !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_done_pulse: done=%b busy=%b, required 0 0", done0, busy0);
    end
  endtask

  // Random back-pressure, random start pulses and inputs changing mid-frame.
  task automatic test_backpressure;
    logic [63:0] fexp;
    logic [3:0]  pat;
    logic        r;
    int          k, cyc;
    pat = 4'b1001;
    for (int f = 0; f < 6; f++) begin
      if (f == 0) set_basic_inputs; else randomize_inputs;
      fexp = cur_frame();
      start = 1'b1;
      tick;
      start = 1'b0;
      k = 0; cyc = 0;
      while (k < 8 && cyc < 64) begin
        n_cmp++;
        if (valid0 !== 1'b1 || busy0 !== 1'b1 || done0 !== 1'b0 || data0 !== fexp[8*k +: 8]) begin
          n_bad++;
          $display("FAIL bp_f%0d_byte%0d: data=%h valid=%b busy=%b done=%b, required %h 1 1 0",
                   f, k, data0, valid0, busy0, done0, fexp[8*k +: 8]);
        end
        r = (f == 0) ? pat[cyc % 4] : 1'($urandom_range(0, 1));
        ready = r;
        start = 1'($urandom_range(0, 1));
        randomize_inputs;
        cyc++;
        tick;
        if (r) k++;
      end
      if (k < 8) begin
        n_cmp++; n_bad++;
        $display("FAIL bp_f%0d_timeout: accepted=%0d, required 8", f, k);
      end
      start = 1'b0;
      ready = 1'($urandom_range(0, 1));
      n_cmp++;
      if (done0 !== 1'b1 || valid0 !== 1'b0 || busy0 !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_f%0d_done: done=%b valid=%b busy=%b, required 1 0 0", f, done0, valid0, busy0);
      end
      tick;
      n_cmp++;
      if (done0 !== 1'b0 || valid0 !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_f%0d_no_requeue: done=%b valid=%b, required 0 0", f, done0, valid0);
      end
    end
  endtask

  task automatic test_snapshot;
    set_basic_inputs;
    ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    int_v = 8'hFF;
    for (int k = 1; k < 8; k++) begin
      n_cmp++;
      if (valid0 !== 1'b1 || data0 !== BASIC_FRAME[8*k +: 8]) begin
        n_bad++;
        $display("FAIL snapshot_byte%0d: data=%h valid=%b, required %h 1",
                 k, data0, valid0, BASIC_FRAME[8*k +: 8]);
      end
      tick;
    end
    n_cmp++;
    if (done0 !== 1'b1) begin
      n_bad++;
      $display("FAIL snapshot_done: done=%b, required 1", done0);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    logic [63:0] fexp;
    randomize_inputs;
    fexp = cur_frame();
    ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int fr = 0; fr < 2; fr++) begin
      for (int k = 0; k < 8; k++) begin
        n_cmp++;
        if (valid0 !== 1'b1 || data0 !== fexp[8*k +: 8]) begin
          n_bad++;
          $display("FAIL b2b_f%0d_byte%0d: data=%h valid=%b, required %h 1",
                   fr, k, data0, valid0, fexp[8*k +: 8]);
        end
        tick;
      end
      n_cmp++;
      if (done0 !== 1'b1 || busy0 !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_f%0d_done: done=%b busy=%b, required 1 0", fr, done0, busy0);
      end
      if (fr == 0) begin
        randomize_inputs;
        fexp = cur_frame();
        start = 1'b1;
        tick;
        start = 1'b0;
      end
    end
    tick;
  endtask

  task automatic test_auto_restart;
    logic [63:0] fexp;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    set_basic_inputs;
    fexp = cur_frame();
    ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int fr = 0; fr < 3; fr++) begin
      for (int k = 0; k < 8; k++) begin
        n_cmp++;
        if (valid4 !== 1'b1 || busy4 !== 1'b1 || data4 !== fexp[8*k +: 8]) begin
          n_bad++;
          $display("FAIL auto_f%0d_byte%0d: data=%h valid=%b busy=%b, required %h 1 1",
                   fr, k, data4, valid4, busy4, fexp[8*k +: 8]);
        end
        tick;
      end
      n_cmp++;
      if (done4 !== 1'b1 || busy4 !== 1'b1 || valid4 !== 1'b0) begin
        n_bad++;
        $display("FAIL auto_f%0d_done: done=%b busy=%b valid=%b, required 1 1 0",
                 fr, done4, busy4, valid4);
      end
      randomize_inputs;
      fexp = cur_frame();
      start = 1'b1;
      for (int g = 1; g < 4; g++) begin
        tick;
        start = 1'b0;
        n_cmp++;
        if (valid4 !== 1'b0 || busy4 !== 1'b1 || done4 !== 1'b0) begin
          n_bad++;
          $display("FAIL auto_f%0d_gap%0d: valid=%b busy=%b done=%b, required 0 1 0",
                   fr, g, valid4, busy4, done4);
        end
      end
      tick;
    end
  endtask

  task automatic test_reset_mid_frame;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    set_basic_inputs;
    ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick; tick; tick;
    n_cmp++;
    if (valid0 !== 1'b1 || data0 !== 8'h55) begin
      n_bad++;
      $display("FAIL midrst_pre: data=%h valid=%b, required 55 1", data0, valid0);
    end
    rst = 1'b1;
    tick;
    n_cmp++;
    if (data0 !== 8'h00 || valid0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_outputs: data=%h valid=%b busy=%b done=%b, required 00 0 0 0",
               data0, valid0, busy0, done0);
    end
    rst = 1'b0;
    tick;
    n_cmp++;
    if (done0 !== 1'b0 || valid0 !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_no_done: done=%b valid=%b, required 0 0", done0, valid0);
    end
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (valid0 !== 1'b1 || data0 !== BASIC_FRAME[8*k +: 8]) begin
        n_bad++;
        $display("FAIL midrst_byte%0d: data=%h valid=%b, required %h 1",
                 k, data0, valid0, BASIC_FRAME[8*k +: 8]);
      end
      tick;
    end
    n_cmp++;
    if (done0 !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_done: done=%b, required 1", done0);
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_snapshot;
    test_back_to_back;
    test_auto_restart;
    test_reset_mid_frame;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
